// File: rtl/fft_pkg.sv
// Shared FFT datapath types: word width default, selector mode codes, serialiser FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Purpose: common constants and typedefs imported by the mux_nin1_seq slice.
// Ports:   none (package).
package fft_pkg;

  localparam int FFT_WORD_SIZE = 16;

  // Values carried on the mode input of the selector
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SEQ    = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_t;

endpackage

// File: rtl/mux_nin1_seq_if.sv
// Handshake/data bundle between an upstream word source and the N:1 selector/serialiser.
// Latency: n/a (wiring only).
// Backpressure: carries in_ready and out_ready; the selector honours both.
//
// Purpose: groups every non-clock/reset signal of mux_nin1_seq.
// Ports:   master = driver of requests and consumer of output words;
//          slave  = the selector itself.
interface mux_nin1_seq_if
  import fft_pkg::*;
#(
  parameter int WORD_SIZE = FFT_WORD_SIZE,
  parameter int N_IN      = 4
);
  localparam int SEL_W = $clog2(N_IN);

  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic                      start;
  logic                      in_valid;
  logic                      in_ready;
  logic [N_IN*WORD_SIZE-1:0] in_data;
  logic [WORD_SIZE-1:0]      out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;
  logic                      busy;
  logic                      done;

  modport master (
    output mode, sel, start, in_valid, in_data, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    input  mode, sel, start, in_valid, in_data, out_ready,
    output in_ready, out_data, out_valid, out_last, busy, done
  );

endinterface

// File: rtl/mux_nin1.sv
// Combinational N_IN:1 word multiplexer; select values with no matching channel yield zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller owns all flow control.
//
// Purpose: shared word selector used for both DIRECT picks and SEQ streaming.
// Ports:   i_data (N_IN packed words, channel k at [k*WORD_SIZE +: WORD_SIZE]),
//          i_sel (channel index), o_data (selected word).
module mux_nin1 #(
  parameter  int WORD_SIZE = 16,
  parameter  int N_IN      = 4,
  localparam int SEL_W     = $clog2(N_IN)
) (
  input  logic [N_IN*WORD_SIZE-1:0] i_data,
  input  logic [SEL_W-1:0]          i_sel,
  output logic [WORD_SIZE-1:0]      o_data
);

  // Encodings beyond N_IN-1 (non-power-of-two N_IN) match no channel and fall through to 0.
  always_comb begin
    o_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_data = i_data[k*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

endmodule

// File: rtl/mux_nin1_seq.sv
// N_IN:1 word selector with registered output: DIRECT picks one channel, SEQ snapshots and streams all.
// Latency: 1 cycle from accepted in_valid/start to out_valid; SEQ then emits one word per output transfer.
// Backpressure: output held while out_valid & ~out_ready; in_ready low whenever busy or output stalled.
//
// Purpose: butterfly-output selector/serialiser for the 16-point FFT datapath.
// Ports:   clk, rst_n (async active-low); bus (slave modport): mode/sel/start/in_valid/in_data in,
//          in_ready out, out_data/out_valid/out_last out with out_ready in, busy/done status out.
module mux_nin1_seq
  import fft_pkg::*;
#(
  parameter int WORD_SIZE = FFT_WORD_SIZE,
  parameter int N_IN      = 4
) (
  input logic           clk,
  input logic           rst_n,
  mux_nin1_seq_if.slave bus
);

  localparam int               SEL_W   = $clog2(N_IN);
  localparam int               DW      = N_IN * WORD_SIZE;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_IN - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SEL_W-1:0]      r_cnt;
  logic [SEL_W-1:0]      w_cnt_nxt;
  logic [SEL_W-1:0]      w_cnt_inc;
  logic [DW-1:0]         r_snap;
  logic [DW-1:0]         w_snap_nxt;
  logic [WORD_SIZE-1:0]  r_out_data;
  logic [WORD_SIZE-1:0]  w_out_data_nxt;
  logic                  r_out_valid;
  logic                  w_out_valid_nxt;
  logic                  r_out_last;
  logic                  w_out_last_nxt;

  logic [SEL_W-1:0]      w_mux_sel;
  logic [DW-1:0]         w_mux_data;
  logic [WORD_SIZE-1:0]  w_mux_out;
  logic                  w_in_ready;
  logic                  w_xfer;
  logic                  w_done;

  assign w_in_ready = (r_state == ST_IDLE) & (~r_out_valid | bus.out_ready);
  assign w_xfer     = r_out_valid & bus.out_ready;
  assign w_cnt_inc  = r_cnt + 1'b1;

  // While streaming the mux looks one word ahead (counter+1) into the frozen snapshot, so the
  // next word is ready to load on the same edge as the current transfer. A SEQ launch from idle
  // always starts at channel 0, regardless of sel.
  always_comb begin
    if (r_state == ST_SEQ) begin
      w_mux_sel  = w_cnt_inc;
      w_mux_data = r_snap;
    end else begin
      w_mux_sel  = (bus.mode == MODE_SEQ) ? '0 : bus.sel;
      w_mux_data = bus.in_data;
    end
  end

  mux_nin1 #(
    .WORD_SIZE (WORD_SIZE),
    .N_IN      (N_IN)
  ) u_mux (
    .i_data (w_mux_data),
    .i_sel  (w_mux_sel),
    .o_data (w_mux_out)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_snap_nxt      = r_snap;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    w_done          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_out_valid_nxt = 1'b0;
        end
        // mode arbitrates when start and in_valid are both high
        if (w_in_ready) begin
          if (bus.mode == MODE_DIRECT) begin
            if (bus.in_valid) begin
              w_out_data_nxt  = w_mux_out;
              w_out_valid_nxt = 1'b1;
              w_out_last_nxt  = 1'b0;
            end
          end else if (bus.start) begin
            w_snap_nxt      = bus.in_data;
            w_state_nxt     = ST_SEQ;
            w_cnt_nxt       = '0;
            w_out_data_nxt  = w_mux_out;
            w_out_valid_nxt = 1'b1;
            w_out_last_nxt  = 1'b0;
          end
        end
      end

      ST_SEQ: begin
        if (w_xfer) begin
          if (r_out_last) begin
            // done is a strobe on the accepting cycle of the final word
            w_done          = 1'b1;
            w_state_nxt     = ST_IDLE;
            w_cnt_nxt       = '0;
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
          end else begin
            w_cnt_nxt      = w_cnt_inc;
            w_out_data_nxt = w_mux_out;
            w_out_last_nxt = (w_cnt_inc == LAST_CH);
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_snap      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_snap      <= w_snap_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = (r_state == ST_SEQ);
  assign bus.done      = w_done;

endmodule

// File: tb/tb_mux_nin1_seq.sv
// Bench for mux_nin1_seq: a 4-channel and a 3-channel instance share clock and reset.
// Latency: n/a.
// Backpressure: out_ready is driven per cycle from the directed sequence.
module tb_mux_nin1_seq;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        seq;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  localparam logic [63:0] D4_1 = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
  localparam logic [63:0] D4_2 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  localparam logic [47:0] D3_1 = {16'hCCCC, 16'hBBBB, 16'hAAAA};

  always #5 clk = ~clk;

  mux_nin1_seq_if #(.WORD_SIZE(16), .N_IN(4)) if_a ();
  mux_nin1_seq_if #(.WORD_SIZE(16), .N_IN(3)) if_b ();

  mux_nin1_seq #(.WORD_SIZE(16), .N_IN(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  mux_nin1_seq #(.WORD_SIZE(16), .N_IN(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [15:0] d, input logic last, input logic seq);
    exp_t e;
    e = {d, last, seq};
    if (id == 0) q_a.push_back(e);
    else         q_b.push_back(e);
  endtask

  task automatic push_seq(input int id, input logic [63:0] d, input int n);
    logic [63:0] v;
    v = d;
    for (int k = 0; k < n; k++) push(id, v[k*16 +: 16], (k == n - 1), 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares the presented word with the queue head; pops on transfer.
  task automatic mon(input int id, input logic vld, input logic rdy, input logic [15:0] d,
                     input logic last, input logic done, input logic busy);
    exp_t  e;
    string tag;
    tag = (id == 0) ? "a" : "b";
    if (!vld) begin
      chk($sformatf("%s_done_idle", tag), done, 1'b0);
      return;
    end
    if ((id == 0) ? (q_a.size() == 0) : (q_b.size() == 0)) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_unexpected_word: got %0h expected none", tag, d);
      return;
    end
    e = (id == 0) ? q_a[0] : q_b[0];
    chk($sformatf("%s_data", tag), d, e.data);
    chk($sformatf("%s_last", tag), last, e.last);
    chk($sformatf("%s_busy", tag), busy, e.seq);
    chk($sformatf("%s_done", tag), done, rdy & e.seq & e.last);
    if (rdy) begin
      if (id == 0) void'(q_a.pop_front());
      else         void'(q_b.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, if_a.out_valid, if_a.out_ready, if_a.out_data, if_a.out_last, if_a.done, if_a.busy);
      mon(1, if_b.out_valid, if_b.out_ready, if_b.out_data, if_b.out_last, if_b.done, if_b.busy);
    end
  end

  initial begin
    if_a.mode = 1'b0; if_a.sel = '0; if_a.start = 1'b0; if_a.in_valid = 1'b0;
    if_a.in_data = '0; if_a.out_ready = 1'b0;
    if_b.mode = 1'b0; if_b.sel = '0; if_b.start = 1'b0; if_b.in_valid = 1'b0;
    if_b.in_data = '0; if_b.out_ready = 1'b0;

    // reset state
    #12;
    chk("rst_out_data",  if_a.out_data,  16'h0);
    chk("rst_out_valid", if_a.out_valid, 1'b0);
    chk("rst_out_last",  if_a.out_last,  1'b0);
    chk("rst_busy",      if_a.busy,      1'b0);
    chk("rst_done",      if_a.done,      1'b0);
    chk("rst_in_ready",  if_a.in_ready,  1'b1);
    chk("rst_b_valid",   if_b.out_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // DIRECT: sel=2 picks CCCC one cycle later
    if_a.out_ready = 1'b1; if_a.mode = 1'b0; if_a.sel = 2'd2;
    if_a.in_data = D4_1; if_a.in_valid = 1'b1;
    push(0, 16'hCCCC, 1'b0, 1'b0);
    tick();
    if_a.in_valid = 1'b0;
    chk("direct_latency_valid", if_a.out_valid, 1'b1);
    tick();
    chk("direct_valid_clears", if_a.out_valid, 1'b0);

    // DIRECT backpressure, then back-to-back accept on release
    if_a.out_ready = 1'b0; if_a.sel = 2'd2; if_a.in_data = D4_1; if_a.in_valid = 1'b1;
    push(0, 16'hCCCC, 1'b0, 1'b0);
    tick();
    if_a.sel = 2'd1; if_a.in_data = D4_2;
    push(0, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_in_ready_low", if_a.in_ready, 1'b0);
    tick();
    tick();
    if_a.out_ready = 1'b1;
    tick();
    if_a.in_valid = 1'b0;
    chk("bp_b2b_valid", if_a.out_valid, 1'b1);
    tick();
    chk("bp_valid_clears", if_a.out_valid, 1'b0);

    // SEQ burst at full rate
    if_a.mode = 1'b1; if_a.start = 1'b1; if_a.in_data = D4_1;
    push_seq(0, D4_1, 4);
    tick();
    if_a.start = 1'b0;
    chk("seq_busy", if_a.busy, 1'b1);
    tick(); tick(); tick();
    chk("seq_done_on_last", if_a.done, 1'b1);
    tick();
    chk("seq_busy_end",  if_a.busy,      1'b0);
    chk("seq_valid_end", if_a.out_valid, 1'b0);

    // SEQ with stalls, in_data changed and a start during the burst
    if_a.start = 1'b1; if_a.in_data = D4_1;
    push_seq(0, D4_1, 4);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if_a.out_ready = (i % 2 == 0);
      if_a.start = (i == 1);
      if (i == 1) if_a.in_data = D4_2;
    end
    tick();
    chk("stall_busy_end", if_a.busy, 1'b0);

    // reset mid-burst at count 2
    if_a.start = 1'b1; if_a.in_data = D4_1; if_a.out_ready = 1'b1;
    push_seq(0, D4_1, 4);
    tick();
    if_a.start = 1'b0;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_data",  if_a.out_data,  16'h0);
    chk("midrst_out_valid", if_a.out_valid, 1'b0);
    chk("midrst_out_last",  if_a.out_last,  1'b0);
    chk("midrst_busy",      if_a.busy,      1'b0);
    chk("midrst_done",      if_a.done,      1'b0);
    q_a.delete();
    tick();
    rst_n = 1'b1;
    tick();
    if_a.start = 1'b1;
    push_seq(0, D4_1, 4);
    tick();
    if_a.start = 1'b0;
    chk("restart_ch0", if_a.out_data, 16'hAAAA);
    tick(); tick(); tick();
    tick();
    chk("restart_busy_end", if_a.busy, 1'b0);

    // N_IN=3: out-of-range select, then two back-to-back SEQ bursts
    if_b.out_ready = 1'b1; if_b.mode = 1'b0; if_b.sel = 2'd3;
    if_b.in_data = D3_1; if_b.in_valid = 1'b1;
    push(1, 16'h0000, 1'b0, 1'b0);
    tick();
    if_b.sel = 2'd1;
    push(1, 16'hBBBB, 1'b0, 1'b0);
    tick();
    if_b.in_valid = 1'b0;
    tick();
    if_b.mode = 1'b1; if_b.start = 1'b1;
    push_seq(1, {16'h0, D3_1}, 3);
    tick();
    if_b.start = 1'b0;
    tick(); tick();
    chk("b_done_on_last", if_b.done, 1'b1);
    chk("b_last_flag",    if_b.out_last, 1'b1);
    tick();
    chk("b_busy_end", if_b.busy, 1'b0);
    if_b.start = 1'b1;
    push_seq(1, {16'h0, D3_1}, 3);
    tick();
    if_b.start = 1'b0;
    chk("b_wrap_ch0", if_b.out_data, 16'hAAAA);
    tick(); tick();
    tick();
    chk("b_busy_end2", if_b.busy, 1'b0);

    tick(); tick();
    chk("a_drained", q_a.size(), 0);
    chk("b_drained", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
